mc_iter_muldiv: RTL and testbench
=================================

Name: mc_iter_muldiv

Overview:
- Parametrised iterative multiply/divide execution unit for the multicycle CPU.
- Gives the multicycle datapath MUL/DIV instructions. The controller holds its execute state while busy=1 and writes hi/lo back when done=1.
- Generalises the single-cycle ALU path:
  - configurable data width;
  - signed and unsigned modes;
  - start/busy/done handshake;
  - condition flags;
  - divide-by-zero detection.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range ≥4, even.
- CNT_W, $clog2(WIDTH)+1, iteration-counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset
- start  input  1  request; sampled only when busy=0
- op  input  2  00 MULU, 01 MULS, 10 DIVU, 11 DIVS; sampled with start
- a  input  WIDTH  multiplicand / dividend; sampled with start
- b  input  WIDTH  multiplier / divisor; sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle result-valid pulse
- hi  output  WIDTH  MUL: upper product half; DIV: remainder
- lo  output  WIDTH  MUL: lower product half; DIV: quotient
- zero  output  1  result is zero
- neg  output  1  result is negative
- div0  output  1  last DIV had b==0

Behaviour:
- Reset:
  - When rst==0 at a rising edge, state←IDLE and busy, done, hi, lo, zero, neg, div0 ← 0.
  - Reset mid-operation aborts the operation: no done pulse, partial result discarded.
- FSM states: IDLE, PREP, RUN, FIXUP, DONE.
- IDLE / DONE: busy=0. start=1 latches op/a/b and goes to PREP. DONE → IDLE when start=0. start in DONE gives back-to-back operation.
- PREP, 1 cycle, busy=1:
  - For signed ops, capture |a|, |b| and result signs: sign_q = a[W-1]^b[W-1]; sign_r = a[W-1].
  - Load counter with WIDTH.
  - DIV with b==0: skip to DONE with lo=all ones, hi=a, div0=1.
  - Otherwise go to RUN.
- RUN, exactly WIDTH cycles, busy=1:
  - MUL: shift-add, one multiplier bit per cycle, into a 2W accumulator.
  - DIV: restoring, one quotient bit per cycle.
  - Counter decrements each cycle; leave RUN when counter reaches 0.
- FIXUP, 1 cycle, busy=1:
  - Apply signs. MULS: negate the 2W product if sign_q. DIVS: negate quotient if sign_q, negate remainder if sign_r.
  - Register hi/lo/flags.
  - div0 ← 0 for non-zero-divisor ops.
- DONE, 1 cycle: done=1.
- Latency: done is high exactly WIDTH+3 edges after the edge that sampled start, or 2 edges for a divide-by-zero.
- hi/lo/flags hold their values until the next FIXUP (or the PREP→DONE divide-by-zero path), or until reset.
- start while busy=1 is ignored. Operands may change freely while busy.
- Signed semantics:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN / −1 → lo=MIN, hi=0, no error flag.
- Flags:
  - zero: MUL → {hi,lo}==0; DIV → lo==0.
  - neg: MULS → hi[W-1]; DIVS → lo[W-1]; unsigned ops → 0.
  - Divide-by-zero path: zero=0, neg=0.
- Arithmetic is full-width with no truncation; the MUL result is always the exact 2W-bit product.

Test Plan:
- Reset, then MULU a=0xFFFFFFFF b=0xFFFFFFFF → done at edge 35 after start; hi=0xFFFFFFFE, lo=0x00000001, zero=0, neg=0; busy high for edges 1–34.
- MULS a=0xFFFFFFFD (−3) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB, neg=1; then MULU a=0 b=5 → hi=lo=0, zero=1.
- DIVS a=0xFFFFFFF9 (−7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, neg=1. DIVS a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=100 b=0 → done at edge 2, div0=1, lo=0xFFFFFFFF, hi=100. Next DIVU 100/7 → lo=14, hi=2, div0=0.
- Start DIVU 1000/3; pulse start with new operands at edge 5 (ignored); drop rst at edge 10 → busy=0, hi=lo=0, no done. Restart DIVU 1000/3 → lo=333, hi=1.
- Back-to-back: assert start during DONE of MULU 6×7 (lo=42) → second op MULU 3×3 accepted with no IDLE gap, lo=9; repeat with WIDTH=8: MULU 0xFF×0xFF → hi=0xFE, lo=0x01, done at edge 11.

Source files
------------

// File: rtl/mc_iter_muldiv.sv
// mc_iter_muldiv: iterative shift-add multiply / restoring divide unit with start/busy/done handshake and flags
module mc_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             neg,
  output logic             div0
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIXUP, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sq_q, sq_d, sr_q, sr_d, zero_q, zero_d, neg_q, neg_d, div0_q, div0_d;
  logic is_div, is_sgn, accept, b_zero;
  logic [WIDTH-1:0] abs_a, abs_b, quo, rem;
  logic [WIDTH:0] mul_sum, div_sh, div_diff;
  assign is_div = op_q[1];
  assign is_sgn = op_q[0];
  assign accept = start && !busy;
  assign b_zero = b_q == '0;
  assign abs_a = is_sgn && a_q[WIDTH-1] ? -a_q : a_q;
  assign abs_b = is_sgn && b_q[WIDTH-1] ? -b_q : b_q;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign div_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_sh - {1'b0, m_q};
  assign prod = is_sgn && sq_q ? -acc_q : acc_q;
  assign quo = is_sgn && sq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem = is_sgn && sr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign hi = hi_q;
  assign lo = lo_q;
  assign zero = zero_q;
  assign neg = neg_q;
  assign div0 = div0_q;
  always_ff @(posedge clk) state_q <= !rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? PREP : IDLE;
      PREP:    state_d = is_div && b_zero ? DONE : RUN;
      RUN:     state_d = cnt_q == CNT_W'(1) ? FIXUP : RUN;
      FIXUP:   state_d = DONE;
      DONE:    state_d = start ? PREP : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy = state_q == PREP || state_q == RUN || state_q == FIXUP;
    done = state_q == DONE;
  end
  always_comb begin
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    m_d = m_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    sq_d = sq_q;
    sr_d = sr_q;
    hi_d = hi_q;
    lo_d = lo_q;
    zero_d = zero_q;
    neg_d = neg_q;
    div0_d = div0_q;
    if (accept) begin
      op_d = op;
      a_d = a;
      b_d = b;
    end
    if (state_q == PREP) begin
      m_d = is_div ? abs_b : abs_a;
      acc_d = {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
      cnt_d = CNT_W'(WIDTH);
      sq_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
      sr_d = a_q[WIDTH-1];
      if (is_div && b_zero) begin
        hi_d = a_q;
        lo_d = '1;
        zero_d = 1'b0;
        neg_d = 1'b0;
        div0_d = 1'b1;
      end
    end
    if (state_q == RUN) begin
      cnt_d = cnt_q - CNT_W'(1);
      acc_d = !is_div ? {mul_sum, acc_q[WIDTH-1:1]} :
              div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0} :
              {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
    if (state_q == FIXUP) begin
      hi_d = is_div ? rem : prod[2*WIDTH-1:WIDTH];
      lo_d = is_div ? quo : prod[WIDTH-1:0];
      zero_d = is_div ? quo == '0 : prod == '0;
      neg_d = is_sgn && (is_div ? quo[WIDTH-1] : prod[2*WIDTH-1]);
      div0_d = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      sq_q <= 1'b0;
      sr_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      zero_q <= 1'b0;
      neg_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sq_q <= sq_d;
      sr_q <= sr_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      zero_q <= zero_d;
      neg_q <= neg_d;
      div0_q <= div0_d;
    end
endmodule

// File: tb/tb_mc_iter_muldiv.sv
// tb_mc_iter_muldiv: scoreboard bench for mc_iter_muldiv at WIDTH=32 and WIDTH=8
module tb_mc_iter_muldiv;
  typedef struct packed {logic [7:0] lat; logic [31:0] hi; logic [31:0] lo; logic z; logic n; logic d0;} res_t;
  typedef struct packed {logic [1:0] op; logic [31:0] a; logic [31:0] b;} req_t;
  logic clk = 0, rst = 0, start = 0;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0, hi, lo;
  logic busy, done, zero, neg, div0;
  logic start8 = 0;
  logic [1:0] op8 = 0;
  logic [7:0] a8 = 0, b8 = 0, hi8, lo8;
  logic busy8, done8, zero8, neg8, div08;
  int checks = 0, errors = 0;
  res_t exp_q[$];
  always #5 clk = ~clk;
  mc_iter_muldiv #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .zero(zero), .neg(neg), .div0(div0)
  );
  mc_iter_muldiv #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .zero(zero8), .neg(neg8), .div0(div08)
  );
  function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t r;
    logic [63:0] p;
    r = '0;
    r.lat = (o[1] && y == 0) ? 8'd2 : 8'd35;
    if (o == 2'd0) begin
      p = {32'b0, x} * {32'b0, y};
      {r.hi, r.lo} = p;
      r.z = p == 0;
    end else if (o == 2'd1) begin
      p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      {r.hi, r.lo} = p;
      r.z = p == 0;
      r.n = p[63];
    end else if (y == 0) begin
      r.hi = x;
      r.lo = 32'hFFFF_FFFF;
      r.d0 = 1;
    end else if (o == 2'd2) begin
      r.lo = x / y;
      r.hi = x % y;
      r.z = r.lo == 0;
    end else begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        r.lo = x;
        r.hi = 0;
      end else begin
        r.lo = $signed(x) / $signed(y);
        r.hi = $signed(x) % $signed(y);
      end
      r.z = r.lo == 0;
      r.n = r.lo[31];
    end
    return r;
  endfunction
  function automatic string fmt(input res_t r);
    return $sformatf("lat=%0d hi=%h lo=%h z=%b n=%b d0=%b", r.lat, r.hi, r.lo, r.z, r.n, r.d0);
  endfunction
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o;
    a = x;
    b = y;
    start = 1;
    exp_q.push_back(model(o, x, y));
  endtask
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    do begin
      @(negedge clk);
      start = 0;
      n++;
      if (busy) nb++;
    end while (!done && n < 100);
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, hi, lo, zero, neg, div0} !== '0) begin
      errors++;
      $display("FAIL reset32: got busy=%b done=%b hi=%h lo=%h z=%b n=%b d0=%b, expected all zero", busy, done, hi, lo, zero, neg, div0);
    end
    checks++;
    if ({busy8, done8, hi8, lo8, zero8, neg8, div08} !== '0) begin
      errors++;
      $display("FAIL reset8: got busy=%b done=%b hi=%h lo=%h, expected all zero", busy8, done8, hi8, lo8);
    end
    rst = 1;
    @(negedge clk);
  endtask
  task automatic test_mul;
    req_t tbl[5] = '{'{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, '{2'd1, 32'hFFFF_FFFD, 32'd7},
                     '{2'd0, 32'd0, 32'd5}, '{2'd1, 32'h8000_0000, 32'h8000_0000},
                     '{2'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFE}};
    int n, nb;
    res_t e, obs;
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_done(n, nb);
      obs = {8'(n), hi, lo, zero, neg, div0};
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mul[%0d]: got %s, expected %s", i, fmt(obs), fmt(e));
      end
      checks++;
      if (nb != 34) begin
        errors++;
        $display("FAIL mul_busy[%0d]: busy for %0d cycles, expected 34", i, nb);
      end
      @(negedge clk);
      checks++;
      if (done || busy || hi !== e.hi || lo !== e.lo) begin
        errors++;
        $display("FAIL mul_hold[%0d]: done=%b busy=%b hi=%h lo=%h, expected 0 0 %h %h", i, done, busy, hi, lo, e.hi, e.lo);
      end
    end
  endtask
  task automatic test_div;
    req_t tbl[7] = '{'{2'd3, 32'hFFFF_FFF9, 32'd2}, '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF},
                     '{2'd2, 32'd100, 32'd0}, '{2'd2, 32'd100, 32'd7}, '{2'd3, 32'd7, 32'hFFFF_FFFE},
                     '{2'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE}, '{2'd2, 32'd3, 32'd9}};
    int n, nb;
    res_t e, obs;
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_done(n, nb);
      obs = {8'(n), hi, lo, zero, neg, div0};
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL div[%0d]: got %s, expected %s", i, fmt(obs), fmt(e));
      end
      checks++;
      if (nb != int'(e.lat) - 1) begin
        errors++;
        $display("FAIL div_busy[%0d]: busy for %0d cycles, expected %0d", i, nb, int'(e.lat) - 1);
      end
    end
  endtask
  task automatic test_reset_abort;
    int n, nb;
    bit saw;
    res_t e, obs;
    saw = 0;
    issue(2'd2, 32'd1000, 32'd3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = k == 5;
      if (k == 5) begin
        op = 2'd0;
        a = 32'd5;
        b = 32'd1;
      end
      if (done) saw = 1;
      if (k == 10) rst = 0;
    end
    @(negedge clk);
    rst = 1;
    checks++;
    if (busy || done || hi !== 0 || lo !== 0 || saw) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b hi=%h lo=%h saw_done=%b, expected 0 0 0 0 0", busy, done, hi, lo, saw);
    end
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw = 1;
    end
    checks++;
    if (saw) begin
      errors++;
      $display("FAIL abort_idle: unit became busy/done after reset, expected idle");
    end
    void'(exp_q.pop_front());
    issue(2'd2, 32'd1000, 32'd3);
    wait_done(n, nb);
    obs = {8'(n), hi, lo, zero, neg, div0};
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL abort_restart: got %s, expected %s", fmt(obs), fmt(e));
    end
  endtask
  task automatic test_back_to_back;
    int n, nb;
    res_t e, obs;
    issue(2'd0, 32'd6, 32'd7);
    wait_done(n, nb);
    obs = {8'(n), hi, lo, zero, neg, div0};
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL b2b_first: got %s, expected %s", fmt(obs), fmt(e));
    end
    issue(2'd0, 32'd3, 32'd3);
    wait_done(n, nb);
    obs = {8'(n), hi, lo, zero, neg, div0};
    e = exp_q.pop_front();
    checks++;
    if (obs !== e || nb != 34) begin
      errors++;
      $display("FAIL b2b_second: got %s busy=%0d, expected %s busy=34", fmt(obs), nb, fmt(e));
    end
    op8 = 2'd0;
    a8 = 8'hFF;
    b8 = 8'hFF;
    start8 = 1;
    n = 0;
    do begin
      @(negedge clk);
      start8 = 0;
      n++;
    end while (!done8 && n < 50);
    checks++;
    if ({8'(n), hi8, lo8, zero8, neg8, div08} !== {8'd11, 8'hFE, 8'h01, 3'b000}) begin
      errors++;
      $display("FAIL w8_ff: got lat=%0d hi=%h lo=%h z=%b n=%b d0=%b, expected lat=11 hi=fe lo=01 z=0 n=0 d0=0", n, hi8, lo8, zero8, neg8, div08);
    end
    a8 = 8'h0F;
    b8 = 8'h0E;
    start8 = 1;
    n = 0;
    nb = 0;
    do begin
      @(negedge clk);
      start8 = 0;
      n++;
      if (busy8) nb++;
    end while (!done8 && n < 50);
    checks++;
    if (n != 11 || nb != 10 || hi8 !== 8'h00 || lo8 !== 8'hD2) begin
      errors++;
      $display("FAIL w8_b2b: got lat=%0d busy=%0d hi=%h lo=%h, expected lat=11 busy=10 hi=00 lo=d2", n, nb, hi8, lo8);
    end
  endtask
  task automatic test_random;
    int n, nb;
    logic [31:0] y;
    res_t e, obs;
    for (int i = 0; i < 16; i++) begin
      y = $urandom_range(0, 5) == 0 ? 32'd0 : ($urandom_range(0, 1) == 1 ? $urandom : 32'($urandom_range(1, 20)));
      issue(2'($urandom_range(0, 3)), $urandom, y);
      wait_done(n, nb);
      obs = {8'(n), hi, lo, zero, neg, div0};
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h: got %s, expected %s", i, op, a, b, fmt(obs), fmt(e));
      end
    end
  endtask
  initial begin
    test_reset();
    test_mul();
    test_div();
    test_reset_abort();
    test_back_to_back();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
